// File: rtl/booth_multiplier_seq_if.sv
// Handshake and result bundle between the control unit and booth_multiplier_seq.
// The optional ovf flag exists only when MUL_OVERFLOW_EN is defined.
interface booth_multiplier_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;
`ifdef MUL_OVERFLOW_EN
    logic             ovf;

    // Control unit side: issues requests and collects the product and overflow flag
    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product_hi, product_lo, ovf
    );

    // Multiplier side
    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product_hi, product_lo, ovf
    );
`else
    // Control unit side: issues requests and collects the product
    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product_hi, product_lo
    );

    // Multiplier side
    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product_hi, product_lo
    );
`endif
endinterface

// File: rtl/booth_multiplier_seq.sv
// Sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier, radix-4 Booth, one digit per clock.
// WIDTH must be even. Define MUL_OVERFLOW_EN to add the registered ovf flag, which is set
// when the product does not fit in WIDTH signed bits.
// Timing: start accepted at edge 0, WIDTH/2 iterations on the following edges, one more edge
// enters DONE and registers the product, so done is high after edge WIDTH/2+1.
module booth_multiplier_seq #(
    parameter int WIDTH = 32
) (
    input logic                  clk,
    input logic                  clr,
    booth_multiplier_seq_if.slave bus
);
    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = $clog2(HALF + 1);
    localparam int AW    = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [AW-1:0]    m_ext;
    logic [AW-1:0]    acc_a;
    logic [WIDTH-1:0] acc_q;
    logic             q_m1;
    logic [AW-1:0]    digit;
    logic [AW-1:0]    sum_a;
    logic             accept;
    logic             last_iter;

    // A new request is only honoured when no operation is in flight
    assign accept    = bus.start && ((state == IDLE) || (state == DONE));
    // All digits consumed: this edge moves to DONE and captures the product
    assign last_iter = (state == RUN) && (count == CNT_W'(HALF));

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE may chain straight into a new RUN
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded purely from the state, so busy and done are exclusive
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Booth digit from the low multiplier pair plus the previously shifted-out bit
    always_comb begin
        digit = '0;
        case ({acc_q[1:0], q_m1})
            3'b001, 3'b010: digit = m_ext;
            3'b011:         digit = {m_ext[AW-2:0], 1'b0};
            3'b100:         digit = AW'(0) - {m_ext[AW-2:0], 1'b0};
            3'b101, 3'b110: digit = AW'(0) - m_ext;
            default:        digit = '0;
        endcase
        sum_a = acc_a + digit;
    end

    // Operand capture and one add/arithmetic-shift-by-two step per RUN cycle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
            m_ext <= '0;
            acc_a <= '0;
            acc_q <= '0;
            q_m1  <= 1'b0;
        end else if (accept) begin
            count <= '0;
            m_ext <= {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
            acc_a <= '0;
            acc_q <= bus.multiplier;
            q_m1  <= 1'b0;
        end else if ((state == RUN) && !last_iter) begin
            count <= count + CNT_W'(1);
            acc_a <= {{2{sum_a[AW-1]}}, sum_a[AW-1:2]};
            acc_q <= {sum_a[1:0], acc_q[WIDTH-1:2]};
            q_m1  <= acc_q[1];
        end
    end

    // Result registers, loaded only on entry to DONE and held until the next completion
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus.product_hi <= '0;
            bus.product_lo <= '0;
`ifdef MUL_OVERFLOW_EN
            bus.ovf        <= 1'b0;
`endif
        end else if (last_iter) begin
            bus.product_hi <= acc_a[WIDTH-1:0];
            bus.product_lo <= acc_q;
`ifdef MUL_OVERFLOW_EN
            bus.ovf        <= (acc_a[WIDTH-1:0] != {WIDTH{acc_q[WIDTH-1]}});
`endif
        end
    end

endmodule
